// File: rtl/care_pkg.sv
// Shared types and constants for the care scheduler: FSM encoding, action indices
// and the round-robin pointer helper.
package care_pkg;

  localparam int unsigned NUM_ACTIONS     = 6;
  localparam int unsigned ACT_FEED        = 0;
  localparam int unsigned ACT_PLAY        = 1;
  localparam int unsigned ACT_HEAL        = 2;
  localparam int unsigned ACT_CLEAN       = 3;
  localparam int unsigned ACT_REST        = 4;
  localparam int unsigned ACT_SOCIAL      = 5;
  localparam int unsigned REST_MIN_ENERGY = 5;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StGrant = 2'd1,
    StCool  = 2'd2
  } state_e;

  // Pointer value that follows a grant to the one-hot winner, wrapping 5 -> 0.
  function automatic logic [2:0] ptr_after(input logic [NUM_ACTIONS-1:0] win);
    logic [2:0] p;
    p = 3'd0;
    for (int i = 0; i < NUM_ACTIONS; i++) begin
      if (win[i]) p = (i == NUM_ACTIONS - 1) ? 3'd0 : 3'(i + 1);
    end
    return p;
  endfunction

endpackage

// File: rtl/care_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set mask bit searching
// upward from the pointer, wrapping past the top action.
module rr_arbiter
  import care_pkg::*;
(
  input  logic [NUM_ACTIONS-1:0] i_mask,
  input  logic [2:0]             i_ptr,
  output logic [NUM_ACTIONS-1:0] o_winner,
  output logic                   o_valid
);

  always_comb begin
    logic [3:0] v_idx;
    logic       v_found;
    v_idx    = 4'd0;
    v_found  = 1'b0;
    o_winner = '0;
    for (int i = 0; i < NUM_ACTIONS; i++) begin
      v_idx = 4'(i_ptr) + 4'(i);
      if (v_idx >= 4'(NUM_ACTIONS)) v_idx = v_idx - 4'(NUM_ACTIONS);
      if (!v_found && i_mask[v_idx[2:0]]) begin
        o_winner[v_idx[2:0]] = 1'b1;
        v_found              = 1'b1;
      end
    end
    o_valid = v_found;
  end

endmodule

// File: rtl/care_scheduler.sv
// Care action scheduler: edge-captured requests, round-robin grant with cooldown,
// and a free-running decay tick. Define REST_GUARD_EN to hold rest until energy >= 5.
module care_scheduler
  import care_pkg::*;
#(
  parameter int unsigned TICK_PERIOD = 10000,
  parameter int unsigned COOLDOWN    = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_ACTIONS-1:0] req,
  input  logic [7:0]             random,
  input  logic [3:0]             energy,
  output logic [NUM_ACTIONS-1:0] grant,
  output logic                   tick,
  output logic [1:0]             decay_sel,
  output logic                   busy
);

  localparam logic [7:0]  CoolLast = (COOLDOWN == 0) ? 8'd0 : 8'(COOLDOWN - 1);
  localparam logic [15:0] TickLast = 16'(TICK_PERIOD - 1);

  state_e                 r_state, w_state_d;
  logic [NUM_ACTIONS-1:0] r_req, r_pending, r_grant;
  logic [NUM_ACTIONS-1:0] w_rise, w_elig, w_win, w_grant_d, w_pending_d;
  logic                   w_win_valid, w_take;
  logic [2:0]             r_ptr, w_ptr_d;
  logic [7:0]             r_cool, w_cool_d;
  logic [15:0]            r_tick_cnt;
  logic                   r_tick;
  logic [1:0]             r_decay_sel;
  logic                   w_unused_bits;

  assign w_rise        = req & ~r_req;
  assign w_unused_bits = ^{random[7:2], energy};

`ifdef REST_GUARD_EN
  // Rest stays pending but is hidden from the arbiter while energy is low.
  always_comb begin
    w_elig = r_pending;
    if (energy < 4'(REST_MIN_ENERGY)) w_elig[ACT_REST] = 1'b0;
  end
`else
  assign w_elig = r_pending;
`endif

  rr_arbiter u_arb (
    .i_mask   (w_elig),
    .i_ptr    (r_ptr),
    .o_winner (w_win),
    .o_valid  (w_win_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_win_valid) w_state_d = StGrant;
      StGrant: w_state_d = (COOLDOWN == 0) ? StIdle : StCool;
      StCool:  if (r_cool == 8'd0) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_take    = (r_state == StIdle) && w_win_valid;
    w_grant_d = w_take ? w_win : '0;
    // A fresh edge on the bit being granted re-arms it.
    w_pending_d = (r_pending & ~w_grant_d) | w_rise;
    w_ptr_d     = w_take ? ptr_after(w_win) : r_ptr;
    w_cool_d    = r_cool;
    if (r_state == StGrant)                       w_cool_d = CoolLast;
    else if (r_state == StCool && r_cool != 8'd0) w_cool_d = r_cool - 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_req       <= '0;
      r_pending   <= '0;
      r_grant     <= '0;
      r_ptr       <= 3'd0;
      r_cool      <= 8'd0;
      r_tick_cnt  <= 16'd0;
      r_tick      <= 1'b0;
      r_decay_sel <= 2'd0;
    end else begin
      r_req     <= req;
      r_pending <= w_pending_d;
      r_grant   <= w_grant_d;
      r_ptr     <= w_ptr_d;
      r_cool    <= w_cool_d;
      if (r_tick_cnt == TickLast) begin
        r_tick_cnt  <= 16'd0;
        r_tick      <= 1'b1;
        r_decay_sel <= random[1:0];
      end else begin
        r_tick_cnt <= r_tick_cnt + 16'd1;
        r_tick     <= 1'b0;
      end
    end
  end

  assign grant     = r_grant;
  assign tick      = r_tick;
  assign decay_sel = r_decay_sel;
  assign busy      = (r_state != StIdle);

endmodule

// File: tb/tb_care_scheduler.sv
// Scoreboard bench for care_scheduler: directed request patterns push expected
// grants with their cycle stamps; a monitor pops and compares every grant seen.
module tb_care_scheduler;

  localparam int unsigned TbTick = 5;
  localparam int unsigned TbCool = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] req;
  logic [7:0] rnd;
  logic [3:0] energy;
  logic [5:0] grant;
  logic       tick;
  logic [1:0] decay_sel;
  logic       busy;

  typedef struct {
    int         at;
    logic [5:0] g;
  } exp_t;

  exp_t exp_q[$];
  int   cyc;
  logic [1:0] exp_sel;
  int   checks = 0;
  int   errors = 0;

  care_scheduler #(
    .TICK_PERIOD (TbTick),
    .COOLDOWN    (TbCool)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .random    (rnd),
    .energy    (energy),
    .grant     (grant),
    .tick      (tick),
    .decay_sel (decay_sel),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Cycles since reset release, and the decay_sel value a correct design holds.
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  always @(posedge clk) begin
    if (reset)                      exp_sel <= 2'd0;
    else if ((cyc + 1) % TbTick == 0) exp_sel <= rnd[1:0];
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int at, input logic [5:0] g);
    exp_t e;
    e.at = at;
    e.g  = g;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
    end
  endtask

  // Monitor: grants against the scoreboard, ticks and decay_sel against the cycle model.
  initial begin
    exp_t e;
    logic exp_tick;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        if (grant !== 6'd0) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL grant_unexpected cyc=%0d got=%b want=none", cyc, grant);
          end else begin
            e = exp_q.pop_front();
            if (e.g !== grant || e.at != cyc) begin
              errors++;
              $display("FAIL grant cyc=%0d got=%b want=%b@%0d", cyc, grant, e.g, e.at);
            end
          end
        end
        exp_tick = (cyc != 0) && (cyc % TbTick == 0);
        if (tick !== 1'b0 || exp_tick) chk("tick", 8'(tick), 8'(exp_tick));
        if (exp_tick || cyc % TbTick == 2) chk("decay_sel", 8'(decay_sel), 8'(exp_sel));
      end
    end
  end

  initial begin
    int c;
    int d;
    reset  = 1'b1;
    req    = 6'd0;
    rnd    = 8'hA7;
    energy = 4'd8;
    step(3);
    chk("rst_grant", 8'(grant), 8'h00);
    chk("rst_busy", 8'(busy), 8'h00);
    chk("rst_tick", 8'(tick), 8'h00);
    chk("rst_decay_sel", 8'(decay_sel), 8'h00);
    reset = 1'b0;
    step(2);

    // Single request from idle, busy spans grant plus cooldown.
    c = cyc;
    req = 6'b000001;
    push(c + 2, 6'b000001);
    for (int k = 1; k <= 7; k++) begin
      step(1);
      req = 6'd0;
      chk("busy_window", 8'(busy), 8'((k >= 2 && k <= 5) ? 1 : 0));
    end
    step(3);

    // Three simultaneous requests served in round-robin order.
    c = cyc;
    req = 6'b101010;
    push(c + 2, 6'b000010);
    push(c + 7, 6'b001000);
    push(c + 12, 6'b100000);
    step(1);
    req = 6'd0;
    step(16);

    // Pointer wrap: after bit 3, search from 4 reaches 0 before 2.
    c = cyc;
    req = 6'b001000;
    push(c + 2, 6'b001000);
    step(1);
    req = 6'd0;
    step(8);
    c = cyc;
    req = 6'b000101;
    push(c + 2, 6'b000001);
    push(c + 7, 6'b000100);
    step(1);
    req = 6'd0;
    step(12);

    // Held request grants once; random changes so decay_sel must track it.
    rnd = 8'h5C;
    c = cyc;
    req = 6'b000100;
    push(c + 2, 6'b000100);
    step(100);
    req = 6'd0;
    rnd = 8'hA7;
    step(6);

    // Edges during cooldown stay pending and a double edge counts once.
    c = cyc;
    req = 6'b000010;
    push(c + 2, 6'b000010);
    push(c + 7, 6'b001000);
    step(1);
    req = 6'd0;
    step(2);
    req = 6'b001000;
    step(1);
    req = 6'd0;
    step(1);
    req = 6'b001000;
    step(1);
    req = 6'd0;
    step(10);

    // New edge on the bit being granted wins over its clear.
    c = cyc;
    req = 6'b000010;
    push(c + 2, 6'b000010);
    push(c + 7, 6'b000001);
    push(c + 12, 6'b000001);
    step(1);
    req = 6'b000001;
    step(1);
    req = 6'd0;
    step(4);
    req = 6'b000001;
    step(1);
    req = 6'd0;
    step(12);

    // Rest request against low energy.
    energy = 4'd4;
    c = cyc;
`ifdef REST_GUARD_EN
    req = 6'b010000;
    step(1);
    req = 6'd0;
    step(10);
    d = cyc;
    energy = 4'd5;
    push(d + 1, 6'b010000);
    step(8);
`else
    push(c + 2, 6'b010000);
    req = 6'b010000;
    step(1);
    req = 6'd0;
    step(8);
`endif
    energy = 4'd8;

    // Reset mid-cooldown drops the pending socialise request.
    c = cyc;
    req = 6'b000001;
    push(c + 2, 6'b000001);
    step(2);
    req = 6'b100000;
    step(1);
    req = 6'd0;
    reset = 1'b1;
    step(2);
    chk("midrst_grant", 8'(grant), 8'h00);
    chk("midrst_busy", 8'(busy), 8'h00);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      chk("post_rst_busy", 8'(busy), 8'h00);
    end

    // Request held through reset counts as an edge right after release.
    reset = 1'b1;
    req = 6'b000100;
    step(2);
    reset = 1'b0;
    push(2, 6'b000100);
    step(3);
    req = 6'd0;
    step(8);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL grant_missing got=%0d outstanding want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
